// File: rtl/can_fetch_pkg.sv
// Shared types and constants for the CAN frame fetch sequencer.
package can_fetch_pkg;
  localparam int DEF_ADDR_W = 10;
  localparam int DEF_DATA_W = 32;
  localparam logic [31:0] ERR_RETURN = 32'hFFFF_FFFF;

  typedef enum logic [2:0] {IDLE, READ, PUSH, DONE, ERR} state_t;
endpackage

// File: rtl/can_fetch_timeout.sv
// Consecutive-stall counter; expired pulses on the TIMEOUT-th stalled cycle.
module can_fetch_timeout #(
  parameter int TIMEOUT = 255
) (
  input  logic clk,
  input  logic reset,
  input  logic clr,
  input  logic en,
  output logic expired
);
  logic [15:0] cnt;

  // Count stalled cycles, restarting whenever a read completes or a run starts.
  always_ff @(posedge clk or posedge reset) begin
    if (reset)    cnt <= '0;
    else if (clr) cnt <= '0;
    else if (en)  cnt <= cnt + 16'd1;
  end

  // Fires in the cycle that would bring the count to TIMEOUT.
  assign expired = en && (cnt == 16'(TIMEOUT - 1));
endmodule

// File: rtl/can_frame_fetch_ctrl.sv
// Reads a programmed run of words from the padded-data memory and streams
// them to the frame builder, accumulating a 32-bit checksum.
import can_fetch_pkg::*;

module can_frame_fetch_ctrl #(
  parameter int ADDR_W  = DEF_ADDR_W,
  parameter int DATA_W  = DEF_DATA_W,
  parameter int TIMEOUT = 255
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W:0]   num_words,
  output logic [ADDR_W-1:0] address,
  output logic              read,
  input  logic              waitrequest,
  input  logic [DATA_W-1:0] readdata,
  output logic              out_valid,
  output logic [DATA_W-1:0] out_data,
  input  logic              out_ready,
  output logic              busy,
  output logic              finish,
  output logic [31:0]       return_val
);
  localparam logic [ADDR_W:0] NUM_MAX = {1'b1, {ADDR_W{1'b0}}};

  state_t          state;
  logic            start_q;
  logic            start_acc;
  logic [ADDR_W:0] num_q;
  logic [ADDR_W:0] num_clamp;
  logic [ADDR_W:0] word_cnt;
  logic [ADDR_W:0] cnt_next;
  logic [31:0]     checksum;
  logic [31:0]     sum_next;
  logic            tmo_clr;
  logic            tmo_en;
  logic            tmo_expired;

  // A start edge only counts when no run is in flight.
  assign start_acc = start && !start_q &&
                     (state == IDLE || state == DONE || state == ERR);
  assign num_clamp = (num_words > NUM_MAX) ? NUM_MAX : num_words;
  assign cnt_next  = word_cnt + 1'b1;
  assign sum_next  = checksum + 32'(out_data);
  assign tmo_en    = (state == READ) && waitrequest;
  assign tmo_clr   = start_acc || ((state == READ) && !waitrequest);

  can_fetch_timeout #(.TIMEOUT(TIMEOUT)) u_tmo (
    .clk     (clk),
    .reset   (reset),
    .clr     (tmo_clr),
    .en      (tmo_en),
    .expired (tmo_expired)
  );

  // Registered copy of start for edge detection.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) start_q <= 1'b0;
    else       start_q <= start;
  end

  // Sequencer: one word at a time, READ until the memory answers, PUSH until accepted.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state      <= IDLE;
      address    <= '0;
      read       <= 1'b0;
      out_valid  <= 1'b0;
      out_data   <= '0;
      busy       <= 1'b0;
      finish     <= 1'b0;
      return_val <= '0;
      num_q      <= '0;
      word_cnt   <= '0;
      checksum   <= '0;
    end else begin
      case (state)
        IDLE, DONE, ERR: begin
          if (start_acc) begin
            num_q      <= num_clamp;
            word_cnt   <= '0;
            checksum   <= '0;
            return_val <= '0;
            address    <= base_addr;
            if (num_clamp == '0) begin
              // Empty run: report an all-zero checksum straight away.
              state  <= DONE;
              finish <= 1'b1;
            end else begin
              state  <= READ;
              finish <= 1'b0;
              read   <= 1'b1;
              busy   <= 1'b1;
            end
          end
        end
        READ: begin
          if (!waitrequest) begin
            out_data  <= readdata;
            read      <= 1'b0;
            out_valid <= 1'b1;
            state     <= PUSH;
          end else if (tmo_expired) begin
            read       <= 1'b0;
            busy       <= 1'b0;
            finish     <= 1'b1;
            return_val <= ERR_RETURN;
            state      <= ERR;
          end
        end
        PUSH: begin
          if (out_ready) begin
            out_valid <= 1'b0;
            checksum  <= sum_next;
            word_cnt  <= cnt_next;
            if (cnt_next == num_q) begin
              busy       <= 1'b0;
              finish     <= 1'b1;
              return_val <= sum_next;
              state      <= DONE;
            end else begin
              // Address wraps naturally at the top of the memory.
              address <= address + 1'b1;
              read    <= 1'b1;
              state   <= READ;
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_can_frame_fetch_ctrl.sv
// Randomized bench for can_frame_fetch_ctrl with a memory model and a
// queue-based reference of expected addresses, beats and checksum.
module tb_can_frame_fetch_ctrl;
  logic        clk = 1'b0;
  logic        reset;
  logic        start;
  logic [9:0]  base_addr;
  logic [10:0] num_words;
  logic [9:0]  address;
  logic        read;
  logic        waitrequest;
  logic [31:0] readdata;
  logic        out_valid;
  logic [31:0] out_data;
  logic        out_ready;
  logic        busy;
  logic        finish;
  logic [31:0] return_val;

  logic [31:0] mem [0:1023];
  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  assign readdata = mem[address];

  can_frame_fetch_ctrl dut (
    .clk         (clk),
    .reset       (reset),
    .start       (start),
    .base_addr   (base_addr),
    .num_words   (num_words),
    .address     (address),
    .read        (read),
    .waitrequest (waitrequest),
    .readdata    (readdata),
    .out_valid   (out_valid),
    .out_data    (out_data),
    .out_ready   (out_ready),
    .busy        (busy),
    .finish      (finish),
    .return_val  (return_val)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // One complete run. wn/rn: fixed stall cycles per read/beat, negative = random.
  task automatic run_frame(input string tag, input int base, input int num,
                           input int wn, input int rn, input bit poke, input bit expect_err);
    int          eff;
    int          a;
    int          cyc;
    int          stall;
    int          rstall;
    int          overlap;
    int          unstable;
    bit          pending;
    bit          fin;
    logic [31:0] held;
    logic [31:0] exp_sum;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_beat[$];
    logic [31:0] obs_addr[$];
    logic [31:0] obs_beat[$];

    eff = (num > 1024) ? 1024 : num;
    exp_sum = 0;
    for (int i = 0; i < eff; i++) begin
      a = (base + i) % 1024;
      exp_addr.push_back(32'(a));
      exp_beat.push_back(mem[a]);
      exp_sum += mem[a];
    end

    @(negedge clk);
    base_addr = 10'(base); num_words = 11'(num);
    start = 1'b1; waitrequest = 1'b0; out_ready = 1'b0;
    cyc = 0; fin = 0; stall = 0; rstall = 0; overlap = 0; unstable = 0;
    pending = 0; held = '0;
    while (!fin && cyc < 20000) begin
      @(negedge clk);
      cyc++;
      if (cyc == 1) start = 1'b0;
      if (poke && cyc == 3) start = 1'b1;
      if (poke && cyc == 5) start = 1'b0;
      if (finish) begin
        fin = 1;
        break;
      end
      if (read && out_valid) overlap++;
      if (read) begin
        if (wn < 0) waitrequest = 1'($urandom_range(0, 1));
        else        waitrequest = (stall < wn);
        if (waitrequest) stall++;
        else begin
          stall = 0;
          obs_addr.push_back(32'(address));
        end
      end else begin
        waitrequest = 1'($urandom_range(0, 1));
      end
      if (out_valid) begin
        if (pending && out_data !== held) unstable++;
        if (rn < 0) out_ready = 1'($urandom_range(0, 1));
        else        out_ready = (rstall >= rn);
        if (out_ready) begin
          rstall = 0; pending = 0;
          obs_beat.push_back(out_data);
        end else begin
          rstall++; pending = 1; held = out_data;
        end
      end else begin
        out_ready = 1'($urandom_range(0, 1));
        pending = 0;
      end
    end

    chk({tag, " finish"}, 32'(fin), 1);
    if (expect_err) begin
      chk({tag, " err_ret"}, return_val, 32'hFFFF_FFFF);
      chk({tag, " err_read"}, 32'(read), 0);
      chk({tag, " err_busy"}, 32'(busy), 0);
      chk({tag, " err_lat"}, 32'(cyc), 256);
      chk({tag, " err_beats"}, 32'(obs_beat.size()), 0);
    end else begin
      chk({tag, " ret"}, return_val, exp_sum);
      chk({tag, " n_addr"}, 32'(obs_addr.size()), 32'(eff));
      chk({tag, " n_beat"}, 32'(obs_beat.size()), 32'(eff));
      for (int i = 0; i < eff; i++) begin
        if (i < obs_addr.size()) chk({tag, " addr"}, obs_addr[i], exp_addr[i]);
        if (i < obs_beat.size()) chk({tag, " beat"}, obs_beat[i], exp_beat[i]);
      end
      if (wn == 0 && rn == 0) chk({tag, " latency"}, 32'(cyc), 32'(2 * eff + 1));
      chk({tag, " overlap"}, 32'(overlap), 0);
      chk({tag, " unstable"}, 32'(unstable), 0);
    end
    // Result must hold while idle in DONE/ERR.
    held = return_val;
    waitrequest = 1'b0; out_ready = 1'b1;
    repeat (3) @(negedge clk);
    chk({tag, " hold_fin"}, 32'(finish), 1);
    chk({tag, " hold_ret"}, return_val, held);
  endtask

  // Global time limit so the run always ends.
  initial begin
    #2000000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int cnt;
    reset = 1'b1; start = 1'b0; base_addr = '0; num_words = '0;
    waitrequest = 1'b0; out_ready = 1'b0;
    for (int i = 0; i < 1024; i++) mem[i] = $urandom;
    repeat (2) @(negedge clk);
    chk("rst read", 32'(read), 0);
    chk("rst valid", 32'(out_valid), 0);
    chk("rst busy", 32'(busy), 0);
    chk("rst finish", 32'(finish), 0);
    chk("rst ret", return_val, 0);
    chk("rst addr", 32'(address), 0);
    reset = 1'b0;
    repeat (2) @(negedge clk);

    mem[0] = 1; mem[1] = 2; mem[2] = 3; mem[3] = 4;
    run_frame("seq4", 0, 4, 0, 0, 0, 0);
    chk("seq4 sum10", return_val, 10);
    run_frame("wrap_addr", 1022, 4, 0, 0, 0, 0);
    run_frame("stall", 100, 2, 3, 2, 0, 0);
    run_frame("tmo", 7, 3, 100000, 0, 0, 1);
    run_frame("after_tmo", 7, 3, 0, 0, 0, 0);
    run_frame("zero", 0, 0, 0, 0, 0, 0);
    chk("zero ret", return_val, 0);
    run_frame("poke", 300, 6, 0, 0, 1, 0);
    mem[500] = 32'hFFFF_FFFF; mem[501] = 2;
    run_frame("sumwrap", 500, 2, 0, 0, 0, 0);
    chk("sumwrap one", return_val, 1);
    run_frame("clamp", 3, 1100, 0, 0, 0, 0);
    for (int r = 0; r < 10; r++)
      run_frame("rand", int'($urandom_range(0, 1023)), int'($urandom_range(1, 40)), -1, -1, 0, 0);

    // Reset in the middle of PUSH.
    @(negedge clk);
    base_addr = 10'd5; num_words = 11'd4; start = 1'b1;
    waitrequest = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    start = 1'b0;
    cnt = 0;
    while (!out_valid && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    chk("mid pre_valid", 32'(out_valid), 1);
    #2 reset = 1'b1;
    #1;
    chk("mid valid", 32'(out_valid), 0);
    chk("mid read", 32'(read), 0);
    chk("mid busy", 32'(busy), 0);
    chk("mid finish", 32'(finish), 0);
    chk("mid ret", return_val, 0);
    chk("mid data", out_data, 0);
    @(negedge clk);
    reset = 1'b0;
    out_ready = 1'b1;
    repeat (5) @(negedge clk);
    chk("post busy", 32'(busy), 0);
    chk("post read", 32'(read), 0);
    chk("post finish", 32'(finish), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/can_frame_fetch_ctrl.md
Name: can_frame_fetch_ctrl

Overview:
Sequencer for the 1024x32 padded-data memory. On start it reads a programmed run of words over a waitrequest-style read port and streams each word to the CAN frame datapath over a valid/ready handshake. It accumulates a 32-bit checksum and reports completion through finish/return_val. It sits between the top-level start/finish control and the memory plus frame-builder datapath.

Parameters:
ADDR_W, 10, memory word-address width (1024 words)
DATA_W, 32, memory and stream data width
TIMEOUT, 255, consecutive waitrequest-high cycles before abort (1..65535)

Ports:
clk  in  1  clock, all state updates on posedge
reset  in  1  asynchronous, active-high reset
start  in  1  level; rising-edge detected (registered), sampled only in IDLE/DONE/ERR
base_addr  in  ADDR_W  first word address, captured on accepted start
num_words  in  ADDR_W+1  words to fetch, 0..1024, captured on accepted start; >1024 treated as 1024
address  out  ADDR_W  memory read address
read  out  1  memory read request
waitrequest  in  1  memory stall; read completes in a cycle with read=1 and waitrequest=0
readdata  in  DATA_W  valid in the completing cycle
out_valid  out  1  stream word valid
out_data  out  DATA_W  stream word
out_ready  in  1  downstream accept
busy  out  1  high in READ/PUSH
finish  out  1  high in DONE/ERR
return_val  out  32  checksum, or 32'hFFFF_FFFF on error

Behaviour:
- Reset (async assert, sync release): state=IDLE; address=0, read=0, out_valid=0, out_data=0, busy=0, finish=0, return_val=0. Internal count, checksum, timeout counter and start-edge register cleared.
- Accepted start: rising edge of start in IDLE, DONE or ERR. Captures base_addr and num_words, clears count, checksum and finish, and goes to READ. With num_words=0 it goes directly to DONE with return_val=0; finish rises 1 cycle after the edge is registered.
- Start edges in READ/PUSH are ignored. No restart mid-run.
- READ: read=1 and address stable. If waitrequest=0, capture readdata into out_data, read=0 next cycle, go to PUSH. If waitrequest=1, the timeout counter increments.
- Timeout: when the counter reaches TIMEOUT, go to ERR; return_val=32'hFFFF_FFFF. The counter clears on every completed read.
- PUSH: out_valid=1 and out_data held until out_ready=1. On the accept cycle: checksum += out_data (mod 2^32), count += 1.
  - If count+1 == captured num_words: go to DONE; return_val = final checksum, valid in the same cycle finish rises.
  - Otherwise: address = address+1, wrapping 1023->0, and go to READ.
- Minimum per-word latency is 2 cycles (READ with waitrequest=0, then PUSH with out_ready=1). No read is issued while a word is pending in PUSH.
- DONE/ERR: finish=1 and return_val are held until the next accepted start or reset.
- out_ready while out_valid=0 is ignored. waitrequest outside READ is ignored.
- Reset asserted mid-run aborts immediately: read and out_valid drop asynchronously, and no partial checksum is retained.

Decomposition:
- Package can_fetch_pkg holds:
  - state enum {IDLE, READ, PUSH, DONE, ERR}
  - ERR_RETURN = 32'hFFFF_FFFF
  - default widths ADDR_W/DATA_W
- One natural sub-module, can_fetch_timeout: a stall counter with clear/enable inputs and an expired output, parameterised by TIMEOUT.
- The FSM, address counter, word counter and checksum stay in the top module.

Test Plan:
- base_addr=0, num_words=4, memory words 1,2,3,4, waitrequest=0, out_ready=1 -> addresses 0..3 read in order, four out_valid beats 1,2,3,4, finish=1 with return_val=10, total 8 cycles after start edge registered.
- base_addr=1022, num_words=4 -> addresses 1022, 1023, 0, 1 in order, and checksum matches the sum of those words.
- waitrequest high 3 cycles per read, out_ready low 2 cycles per beat, num_words=2 -> no word lost or duplicated, out_data stable while stalled, correct return_val.
- waitrequest stuck high, TIMEOUT=255 -> ERR after 255 stalled cycles, finish=1, return_val=32'hFFFF_FFFF, read=0. A following start with waitrequest=0 completes normally.
- num_words=0 -> no read issued, finish=1, return_val=0. A start edge during a busy run is ignored. Words 32'hFFFF_FFFF and 2 -> return_val=1 (wrap).
- Reset asserted during PUSH -> outputs immediately reach reset values and stay IDLE until a new start edge.
